// File: rtl/seq_rshifter_pkg.sv
// Shared constants for the sequential right shifter: default data and
// shift-amount widths, stage count, FSM state encodings, and a helper that
// gives the shift distance applied by each stage.
package seq_rshifter_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned SHAMT_W    = 5;
  localparam int unsigned NUM_STAGES = SHAMT_W;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
  localparam logic [STATE_W-1:0] ST_SHIFT = 2'b01;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'b10;

  // Stage k shifts by 2^(shamt_w-1-k), so the largest distance goes first.
  function automatic int unsigned stage_dist(input int unsigned shamt_w,
                                             input int unsigned k);
    return 32'd1 << (shamt_w - 32'd1 - k);
  endfunction

endpackage

// File: rtl/seq_rshifter_stage.sv
// One fixed-distance right-shift stage (pure combinational).
//   value     : operand to shift
//   fill      : bit shifted in at the top
//   shifted_c : value >> DIST with fill replicated into the vacated bits
module rshift_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] value,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted_c
);

  assign shifted_c = {{DIST{fill}}, value[WIDTH-1:DIST]};

endmodule

// File: rtl/seq_rshifter.sv
// Multi-cycle right shifter. An accepted request walks through one stage
// per clock (largest distance first); every request takes the same number
// of cycles regardless of the shift amount.
//   clock   : rising-edge clock
//   reset   : asynchronous active-low reset
//   start   : request, sampled only while idle
//   arith   : 1 = sign fill, 0 = zero fill
//   data_in : operand
//   shamt   : shift distance
//   busy    : operation in flight (SHIFT or DONE)
//   done    : one-cycle pulse, result valid
//   result  : shifted value, held until the next completion
module seq_rshifter #(
  parameter int unsigned WIDTH   = seq_rshifter_pkg::WIDTH,
  parameter int unsigned SHAMT_W = seq_rshifter_pkg::SHAMT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               arith,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  import seq_rshifter_pkg::*;

  localparam int unsigned N_STAGES = SHAMT_W;
  localparam int unsigned CNT_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(N_STAGES - 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [WIDTH-1:0]   work, work_nxt;
  logic [SHAMT_W-1:0] cap_shamt, cap_shamt_nxt;
  logic               fill, fill_nxt;
  logic [CNT_W-1:0]   stage_cnt, stage_cnt_nxt;
  logic [WIDTH-1:0]   result_nxt;
  logic               busy_nxt;
  logic               done_nxt;

  // chain[g] carries the selected stage output up through the stage list;
  // only the stage matching stage_cnt replaces the pass-through value.
  logic [WIDTH-1:0] chain [N_STAGES+1];
  logic [WIDTH-1:0] stage_val;

  assign chain[0] = work;

  for (genvar g = 0; g < N_STAGES; g++) begin : g_stage
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] applied;

    rshift_stage #(
      .WIDTH (WIDTH),
      .DIST  (stage_dist(SHAMT_W, g))
    ) u_stage (
      .value     (work),
      .fill      (fill),
      .shifted_c (shifted)
    );

    // A stage only shifts when its captured shamt bit is set.
    assign applied      = cap_shamt[SHAMT_W-1-g] ? shifted : work;
    assign chain[g+1]   = (stage_cnt == CNT_W'(g)) ? applied : chain[g];
  end

  assign stage_val = chain[N_STAGES];

  // Next-state and datapath update.
  always_comb begin
    state_nxt     = state;
    work_nxt      = work;
    cap_shamt_nxt = cap_shamt;
    fill_nxt      = fill;
    stage_cnt_nxt = stage_cnt;
    result_nxt    = result;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt     = ST_SHIFT;
          work_nxt      = data_in;
          cap_shamt_nxt = shamt;
          // Sign is latched once from the original operand.
          fill_nxt      = arith & data_in[WIDTH-1];
          stage_cnt_nxt = '0;
        end
      end
      ST_SHIFT: begin
        work_nxt = stage_val;
        if (stage_cnt == LAST_STAGE) begin
          result_nxt    = stage_val;
          stage_cnt_nxt = '0;
          state_nxt     = ST_DONE;
        end else begin
          stage_cnt_nxt = stage_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      work      <= '0;
      cap_shamt <= '0;
      fill      <= 1'b0;
      stage_cnt <= '0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      work      <= work_nxt;
      cap_shamt <= cap_shamt_nxt;
      fill      <= fill_nxt;
      stage_cnt <= stage_cnt_nxt;
      result    <= result_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_seq_rshifter.sv
// Self-checking bench for seq_rshifter: directed corner cases plus a random
// sweep checked against a plain >> / >>> reference.
module tb_seq_rshifter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        arith;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] prev_res;

  always #5 clock = ~clock;

  seq_rshifter dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .arith   (arith),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  function automatic logic [31:0] ref_shift(input logic [31:0] d,
                                            input logic [4:0]  s,
                                            input logic        a);
    logic [31:0] r;
    if (a) r = $signed(d) >>> s;
    else   r = d >> s;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request now (caller is just after a rising edge), scramble the
  // inputs after acceptance, optionally poke start while busy, then check
  // latency, result, single done pulse and return to idle.
  task automatic run_op(input logic [31:0] d, input logic [4:0] s,
                        input logic a, input bit intrude);
    int          lat;
    int          extra;
    logic [31:0] exp;
    exp     = ref_shift(d, s, a);
    data_in = d;
    shamt   = s;
    arith   = a;
    start   = 1'b1;
    @(posedge clock); #1;
    start   = 1'b0;
    data_in = $urandom;
    shamt   = 5'($urandom);
    arith   = 1'($urandom);
    chk("busy_acc", 32'(busy), 32'd1);
    chk("res_hold", result, prev_res);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (intrude && n == 2) begin
        start   = 1'b1;
        data_in = 32'hFFFF_FFFF;
        shamt   = 5'd1;
        arith   = 1'b0;
      end
      if (intrude && n == 4) start = 1'b0;
      @(posedge clock); #1;
      if (done) begin
        lat = n;
        break;
      end
      if (n < 5) chk("busy_mid", 32'(busy), 32'd1);
    end
    chk("latency", 32'(lat), 32'd5);
    chk("result", result, exp);
    prev_res = exp;
    @(posedge clock); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    if (intrude) begin
      extra = 0;
      repeat (8) begin
        @(posedge clock); #1;
        if (done) extra++;
      end
      chk("intrude_done", 32'(extra), 32'd0);
      chk("intrude_res", result, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int saw;
    reset    = 1'b0;
    start    = 1'b0;
    arith    = 1'b0;
    data_in  = '0;
    shamt    = '0;
    prev_res = '0;
    repeat (2) @(posedge clock); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Directed corners, issued back to back.
    run_op(32'h8000_0000, 5'd31, 1'b1, 1'b0);
    chk("dir_sra31", result, 32'hFFFF_FFFF);
    run_op(32'h8000_0000, 5'd31, 1'b0, 1'b0);
    chk("dir_srl31", result, 32'h0000_0001);
    run_op(32'hF000_0000, 5'd4, 1'b1, 1'b0);
    chk("dir_sra4", result, 32'hFF00_0000);
    run_op(32'h1234_5678, 5'd0, 1'b0, 1'b0);
    chk("dir_zero_l", result, 32'h1234_5678);
    run_op(32'h1234_5678, 5'd0, 1'b1, 1'b0);
    chk("dir_zero_a", result, 32'h1234_5678);
    run_op(32'h0000_FFFF, 5'd8, 1'b0, 1'b1);
    chk("dir_intrude", result, 32'h0000_00FF);

    // Reset in the middle of an operation.
    data_in = 32'hAAAA_AAAA;
    shamt   = 5'd5;
    arith   = 1'b0;
    start   = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", result, 32'd0);
    saw = 0;
    repeat (4) begin
      @(posedge clock); #1;
      if (done) saw++;
    end
    chk("abort_nodone", 32'(saw), 32'd0);
    reset    = 1'b1;
    prev_res = '0;
    @(posedge clock); #1;
    run_op(32'h0000_0100, 5'd8, 1'b0, 1'b0);
    chk("after_abort", result, 32'h0000_0001);

    // Random sweep with occasional idle gaps.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] d;
      d = $urandom;
      if (i % 10 == 0) d = d | 32'h8000_0000;
      run_op(d, 5'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
